// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage core: load-use and MDU stalls, branch/jump flushes, MDU busy FSM.
// Optional HAZARD_STATS_EN adds saturating stall/flush cycle counters (stat_stall, stat_flush).
module hazard_ctrl #(
    parameter int MDU_LAT = 32,
    parameter int CNT_W   = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rt,
    input  logic       id_mdu_op,
    input  logic       id_reads_hilo,
    input  logic       branch_taken,
    input  logic       jump,
    output logic       pc_write,
    output logic       if_id_write,
    output logic       if_id_flush,
    output logic       id_ex_bubble,
    output logic       mdu_busy
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0] stat_stall,
    output logic [31:0] stat_flush
`endif
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;

    logic lu, mh, stall;

    // Load-use: the load in ID/EX writes a register the ID instruction reads; r0 never hazards.
    always_comb begin
        lu = ex_mem_read && (ex_rt != 5'd0) &&
             ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
        mh = (state == BUSY) && (id_mdu_op || id_reads_hilo);
        stall = (lu || mh) && !branch_taken;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // A mult/div on the wrong path of a taken branch is never issued; BUSY is not aborted by branches.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (id_mdu_op && !lu && !branch_taken) begin
                    state_nx = BUSY;
                    cnt_nx   = CNT_W'(MDU_LAT - 1);
                end
            end
            BUSY: begin
                if (cnt != '0) cnt_nx = cnt - 1'b1;
                else           state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        mdu_busy     = 1'b0;
        if (!rst) begin
            mdu_busy = (state == BUSY);
            if (branch_taken) begin
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
            end else if (stall) begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_bubble = 1'b1;
            end else if (jump) begin
                if_id_flush  = 1'b1;
            end
        end
    end

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_stall <= '0;
            stat_flush <= '0;
        end else begin
            if (stall && (stat_stall != 32'hFFFF_FFFF)) stat_stall <= stat_stall + 32'd1;
            if (if_id_flush && (stat_flush != 32'hFFFF_FFFF)) stat_flush <= stat_flush + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios then random stimulus against a cycle-count reference model.
module tb_hazard_ctrl;
    localparam int LAT = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       id_uses_rt, ex_mem_read, id_mdu_op, id_reads_hilo, branch_taken, jump;
    logic       pc_write, if_id_write, if_id_flush, id_ex_bubble, mdu_busy;
`ifdef HAZARD_STATS_EN
    logic [31:0] stat_stall, stat_flush;
`endif

    hazard_ctrl #(.MDU_LAT(LAT), .CNT_W(6)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
        .id_mdu_op(id_mdu_op), .id_reads_hilo(id_reads_hilo),
        .branch_taken(branch_taken), .jump(jump),
        .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
        .id_ex_bubble(id_ex_bubble), .mdu_busy(mdu_busy)
`ifdef HAZARD_STATS_EN
        , .stat_stall(stat_stall), .stat_flush(stat_flush)
`endif
    );

    typedef struct packed {
        logic       rst;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urt;
        logic       mr;
        logic [4:0] ert;
        logic       mdu;
        logic       hilo;
        logic       bt;
        logic       jmp;
    } stim_t;

    int checks = 0;
    int failures = 0;

    // Reference model: remaining busy cycles, and stall/flush edge counts.
    int     busy_left = 0;
    longint m_stall = 0;
    longint m_flush = 0;

    logic        o_pcw, o_fl, o_busy;
    logic [31:0] o_sst, o_sfl;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic stim_t nop();
        stim_t s;
        s = '0;
        return s;
    endfunction

    task automatic step(input stim_t s);
        logic lu, busy, mh, stall, issue;
        logic e_pcw, e_ifw, e_fl, e_bub, e_busy;
        @(negedge clk);
        rst = s.rst; id_rs = s.rs; id_rt = s.rt; id_uses_rt = s.urt;
        ex_mem_read = s.mr; ex_rt = s.ert; id_mdu_op = s.mdu;
        id_reads_hilo = s.hilo; branch_taken = s.bt; jump = s.jmp;
        #1;
        lu    = s.mr && (s.ert != 0) && ((s.ert == s.rs) || (s.urt && (s.ert == s.rt)));
        busy  = (busy_left > 0);
        mh    = busy && (s.mdu || s.hilo);
        stall = (lu || mh) && !s.bt;
        {e_pcw, e_ifw, e_fl, e_bub} = 4'b1100;
        e_busy = busy;
        if (s.rst) e_busy = 1'b0;
        else if (s.bt) {e_pcw, e_ifw, e_fl, e_bub} = 4'b1111;
        else if (stall) {e_pcw, e_ifw, e_fl, e_bub} = 4'b0001;
        else if (s.jmp) {e_pcw, e_ifw, e_fl, e_bub} = 4'b1110;
        o_pcw = pc_write; o_fl = if_id_flush; o_busy = mdu_busy;
        chk("pc_write", 32'(pc_write), 32'(e_pcw));
        chk("if_id_write", 32'(if_id_write), 32'(e_ifw));
        chk("if_id_flush", 32'(if_id_flush), 32'(e_fl));
        chk("id_ex_bubble", 32'(id_ex_bubble), 32'(e_bub));
        chk("mdu_busy", 32'(mdu_busy), 32'(e_busy));
`ifdef HAZARD_STATS_EN
        o_sst = stat_stall; o_sfl = stat_flush;
        chk("stat_stall", stat_stall, 32'(m_stall));
        chk("stat_flush", stat_flush, 32'(m_flush));
`else
        o_sst = '0; o_sfl = '0;
`endif
        @(posedge clk);
        if (s.rst) begin
            busy_left = 0;
            m_stall = 0;
            m_flush = 0;
        end else begin
            issue = !busy && s.mdu && !lu && !s.bt;
            if (busy_left > 0) busy_left--;
            if (issue) busy_left = LAT;
            if (stall && (m_stall < 64'hFFFF_FFFF)) m_stall++;
            if (e_fl && (m_flush < 64'hFFFF_FFFF)) m_flush++;
        end
    endtask

    initial begin
        stim_t s;
        int nb, ns;
        rst = 1'b1; id_rs = '0; id_rt = '0; ex_rt = '0; id_uses_rt = 1'b0;
        ex_mem_read = 1'b0; id_mdu_op = 1'b0; id_reads_hilo = 1'b0;
        branch_taken = 1'b0; jump = 1'b0;
        @(posedge clk);

        // Reset values
        s = nop(); s.rst = 1'b1;
        step(s); step(s);

        // Load-use three times, r0 load never stalls, then two taken branches
        for (int i = 0; i < 3; i++) begin
            s = nop(); s.mr = 1'b1; s.ert = 5'd5; s.rs = 5'd5;
            step(s);
            chk("lu_pc_hold", 32'(o_pcw), 32'd0);
            step(nop());
            chk("lu_one_cycle", 32'(o_pcw), 32'd1);
        end
        s = nop(); s.mr = 1'b1; s.ert = 5'd0; s.rs = 5'd0;
        step(s);
        chk("lu_r0_no_stall", 32'(o_pcw), 32'd1);
        s = nop(); s.mr = 1'b1; s.ert = 5'd7; s.rt = 5'd7; s.urt = 1'b1;
        step(s);
        s = nop(); s.bt = 1'b1;
        step(s); step(s);
        step(nop());
`ifdef HAZARD_STATS_EN
        chk("stat_stall_total", o_sst, 32'd4);
        chk("stat_flush_total", o_sfl, 32'd2);
`endif

        // MDU latency with mfhi held behind it
        s = nop(); s.mdu = 1'b1;
        step(s);
        nb = 0; ns = 0;
        for (int i = 0; i < LAT + 1; i++) begin
            s = nop(); s.hilo = 1'b1;
            step(s);
            if (o_busy) nb++;
            if (!o_pcw) ns++;
        end
        chk("mdu_busy_cycles", 32'(nb), 32'(LAT));
        chk("mfhi_stall_cycles", 32'(ns), 32'(LAT));

        // Back-to-back mult/div: busy drops for one cycle
        s = nop(); s.mdu = 1'b1;
        step(s);
        for (int i = 0; i < LAT; i++) step(s);
        step(s);
        chk("b2b_gap", 32'(o_busy), 32'd0);
        step(nop());
        chk("b2b_reissue", 32'(o_busy), 32'd1);
        for (int i = 0; i < LAT; i++) step(nop());

        // Taken branch overrides a load-use stall and suppresses an MDU issue
        s = nop(); s.mr = 1'b1; s.ert = 5'd3; s.rs = 5'd3; s.mdu = 1'b1; s.bt = 1'b1;
        step(s);
        chk("bt_over_stall", 32'(o_pcw), 32'd1);
        step(nop());
        chk("bt_no_issue", 32'(o_busy), 32'd0);

        // Jump under a stall flushes only once the stall clears
        s = nop(); s.mr = 1'b1; s.ert = 5'd9; s.rs = 5'd9; s.jmp = 1'b1;
        step(s);
        chk("jump_stalled_flush", 32'(o_fl), 32'd0);
        s = nop(); s.jmp = 1'b1;
        step(s);
        chk("jump_late_flush", 32'(o_fl), 32'd1);

        // Reset in the second busy cycle
        s = nop(); s.mdu = 1'b1;
        step(s);
        step(nop());
        s = nop(); s.rst = 1'b1; s.hilo = 1'b1;
        step(s);
        chk("rst_busy_forced", 32'(o_busy), 32'd0);
        step(nop());
        chk("rst_busy_cleared", 32'(o_busy), 32'd0);

        // Random traffic with small register indices so hazards are frequent
        for (int i = 0; i < 600; i++) begin
            s.rst  = ($urandom_range(0, 49) == 0);
            s.rs   = 5'($urandom_range(0, 3));
            s.rt   = 5'($urandom_range(0, 3));
            s.urt  = 1'($urandom_range(0, 1));
            s.mr   = ($urandom_range(0, 2) == 0);
            s.ert  = 5'($urandom_range(0, 3));
            s.mdu  = ($urandom_range(0, 4) == 0);
            s.hilo = ($urandom_range(0, 3) == 0);
            s.bt   = ($urandom_range(0, 5) == 0);
            s.jmp  = ($urandom_range(0, 5) == 0);
            step(s);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
